// File: rtl/store_buffer_coalescing_if.sv
// Bus bundle for store_buffer_coalescing.
// The interface groups three channels:
//   enq_*    : store request from the MEM stage (valid/ready).
//   mem_*    : drain of the head entry toward the cache/memory (valid/ready).
//   lookup_* : combinational load-forwarding query and its result.
// The slave modport is the store buffer's view. The master modport is the view
// of the MEM stage, cache and load unit combined.
interface store_buffer_coalescing_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [BE_W-1:0]   enq_byte_en;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_byte_en;

  logic [ADDR_W-1:0] lookup_addr;
  logic [DATA_W-1:0] lookup_data;
  logic [BE_W-1:0]   lookup_be;
  logic              lookup_hit;

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_byte_en, mem_ready, lookup_addr,
    output enq_ready, mem_valid, mem_addr, mem_data, mem_byte_en,
           lookup_data, lookup_be, lookup_hit
  );

  modport master (
    output enq_valid, enq_addr, enq_data, enq_byte_en, mem_ready, lookup_addr,
    input  enq_ready, mem_valid, mem_addr, mem_data, mem_byte_en,
           lookup_data, lookup_be, lookup_hit
  );
endinterface

// File: rtl/store_buffer_coalescing.sv
// Write-back store buffer placed between the MEM stage and the data cache.
// It keeps byte-masked stores in a circular FIFO and drains them in order.
// Loads get per-byte forwarding from the youngest matching entry. When
// COALESCE=1, a store to the same word as the youngest entry is merged into it.
// Ports:
//   clk, reset : clock; asynchronous active-high reset
//   bus        : enq_* / mem_* / lookup_* channels (slave view)
//   count      : number of occupied entries
//   full/empty : count == DEPTH / count == 0
module store_buffer_coalescing #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  store_buffer_coalescing_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WA_W-1:0]   entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [BE_W-1:0]   entry_be   [DEPTH];

  logic [PTR_W-1:0] head, tail, tail_m1;
  logic [WA_W-1:0]  enq_word, lookup_word;
  logic             coal_ok, enq_fire, do_alloc, do_coal, pop;

  assign enq_word    = bus.enq_addr[ADDR_W-1:OFF_W];
  assign lookup_word = bus.lookup_addr[ADDR_W-1:OFF_W];

  generate
    if (OFF_W > 0) begin : g_unused_offsets
      // The in-word byte offset does not take part in word matching.
      logic unused_offsets;
      assign unused_offsets = ^{bus.enq_addr[OFF_W-1:0], bus.lookup_addr[OFF_W-1:0]};
    end
  endgenerate

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // The entry at tail-1 is the youngest one. Merging requires count >= 2, so
  // the merge target is never the head. This keeps the drain payload stable.
  assign tail_m1 = tail - PTR_W'(1);
  assign coal_ok = (COALESCE != 0) && (count >= CNT_W'(2)) &&
                   (entry_addr[tail_m1] == enq_word);

  assign bus.enq_ready = !full || coal_ok;
  assign enq_fire      = bus.enq_valid && bus.enq_ready;
  // A store with an empty byte mask is accepted but changes nothing.
  assign do_coal       = enq_fire && (|bus.enq_byte_en) && coal_ok;
  assign do_alloc      = enq_fire && (|bus.enq_byte_en) && !coal_ok;

  assign bus.mem_valid   = !empty;
  assign pop             = bus.mem_valid && bus.mem_ready;
  assign bus.mem_addr    = {entry_addr[head], {OFF_W{1'b0}}};
  assign bus.mem_data    = entry_data[head];
  assign bus.mem_byte_en = entry_be[head];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_alloc) tail <= tail + PTR_W'(1);
      if (pop)      head <= head + PTR_W'(1);
      count <= count + CNT_W'(do_alloc) - CNT_W'(pop);
    end
  end

  // NOTE: the entry storage has no reset. Validity comes only from
  // head/count, so stale contents are never visible after reset.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entry_addr[tail] <= enq_word;
      entry_data[tail] <= bus.enq_data;
      entry_be[tail]   <= bus.enq_byte_en;
    end else if (do_coal) begin
      for (int l = 0; l < BE_W; l++) begin
        if (bus.enq_byte_en[l]) begin
          entry_data[tail_m1][l*8 +: 8] <= bus.enq_data[l*8 +: 8];
          entry_be[tail_m1][l]          <= 1'b1;
        end
      end
    end
  end

  // Forwarding walks the entries from oldest to youngest. A later match
  // overrides an earlier one, so the youngest store wins each lane.
  logic [DATA_W-1:0] fwd_data;
  logic [BE_W-1:0]   fwd_be;
  logic [PTR_W-1:0]  fwd_idx;

  // NOTE: give every always_comb output a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    fwd_data = '0;
    fwd_be   = '0;
    fwd_idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entry_addr[fwd_idx] == lookup_word)) begin
        for (int l = 0; l < BE_W; l++) begin
          if (entry_be[fwd_idx][l]) begin
            fwd_be[l]            = 1'b1;
            fwd_data[l*8 +: 8]   = entry_data[fwd_idx][l*8 +: 8];
          end
        end
      end
    end
  end

  assign bus.lookup_data = fwd_data;
  assign bus.lookup_be   = fwd_be;
  assign bus.lookup_hit  = |fwd_be;
endmodule

// File: tb/tb_store_buffer_coalescing.sv
// Directed self-checking bench for store_buffer_coalescing.
// It has two instances: dut (COALESCE=1) and dut_nc (COALESCE=0).
module tb_store_buffer_coalescing;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] count, count_nc;
  logic full, empty, full_nc, empty_nc;

  int errors = 0;
  int checks = 0;

  store_buffer_coalescing_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  store_buffer_coalescing_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_nc ();

  store_buffer_coalescing #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .COALESCE(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .count(count), .full(full), .empty(empty)
  );

  store_buffer_coalescing #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .COALESCE(0)) dut_nc (
    .clk(clk), .reset(reset), .bus(bus_nc), .count(count_nc), .full(full_nc), .empty(empty_nc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge, so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.enq_valid = 1'b1; bus.enq_addr = a; bus.enq_data = d; bus.enq_byte_en = be;
    step();
    bus.enq_valid = 1'b0;
  endtask

  task automatic enq_nc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_nc.enq_valid = 1'b1; bus_nc.enq_addr = a; bus_nc.enq_data = d; bus_nc.enq_byte_en = be;
    step();
    bus_nc.enq_valid = 1'b0;
  endtask

  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  initial begin
    reset = 1'b1;
    bus.enq_valid = 1'b0; bus.enq_addr = '0; bus.enq_data = '0; bus.enq_byte_en = '0;
    bus.mem_ready = 1'b0; bus.lookup_addr = '0;
    bus_nc.enq_valid = 1'b0; bus_nc.enq_addr = '0; bus_nc.enq_data = '0; bus_nc.enq_byte_en = '0;
    bus_nc.mem_ready = 1'b0; bus_nc.lookup_addr = '0;
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_enq_ready", bus.enq_ready, 1);
    check("rst_lookup_be", bus.lookup_be, 0);
    check("rst_lookup_hit", bus.lookup_hit, 0);
    check("rst_lookup_data", bus.lookup_data, 0);

    // Single SW, then head payload and forwarding
    enq(32'h100, 32'h0000_0011, 4'hF);
    check("sw_count", count, 1);
    check("sw_mem_valid", bus.mem_valid, 1);
    check("sw_mem_addr", bus.mem_addr, 32'h100);
    check("sw_mem_data", bus.mem_data, 32'h11);
    check("sw_mem_be", bus.mem_byte_en, 4'hF);
    bus.lookup_addr = 32'h102;
    #1;
    check("sw_lk_be", bus.lookup_be, 4'hF);
    check("sw_lk_data", bus.lookup_data, 32'h11);

    // Byte stores: the second allocates because count < 2; the third coalesces
    pulse_reset();
    enq(32'h104, 32'h0000_0080, 4'h1);
    enq(32'h105, 32'h0000_7700, 4'h2);
    check("sb_alloc_count", count, 2);
    bus.lookup_addr = 32'h104;
    #1;
    check("sb_lk_be", bus.lookup_be, 4'h3);
    check("sb_lk_data", bus.lookup_data, 32'h0000_7780);
    enq(32'h106, 32'h0055_0000, 4'h4);
    check("sb_coal_count", count, 2);
    check("sb_coal_lk_be", bus.lookup_be, 4'h7);
    check("sb_coal_lk_data", bus.lookup_data, 32'h0055_7780);
    check("sb_head_be", bus.mem_byte_en, 4'h1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check("sb_pop_count", count, 1);
    check("sb_entry1_addr", bus.mem_addr, 32'h104);
    check("sb_entry1_be", bus.mem_byte_en, 4'h6);
    check("sb_entry1_data", bus.mem_data, 32'h0055_7700);

    // Fill to full, coalesce while full, hold a distinct store, then drain
    pulse_reset();
    enq(32'h20, 32'h2, 4'hF);
    enq(32'h30, 32'h3, 4'hF);
    enq(32'h40, 32'h4, 4'hF);
    enq(32'h50, 32'h5, 4'hF);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    bus.enq_valid = 1'b1; bus.enq_addr = 32'h51; bus.enq_data = 32'h0000_AB00; bus.enq_byte_en = 4'h2;
    #1;
    check("full_coal_ready", bus.enq_ready, 1);
    step();
    check("full_coal_count", count, 4);
    bus.enq_addr = 32'h60; bus.enq_data = 32'h6; bus.enq_byte_en = 4'hF;
    bus.mem_ready = 1'b1;
    #1;
    check("full_hold_ready", bus.enq_ready, 0);
    step();
    bus.mem_ready = 1'b0;
    check("full_pop_count", count, 3);
    check("full_pop_head", bus.mem_addr, 32'h30);
    check("held_ready", bus.enq_ready, 1);
    step();
    bus.enq_valid = 1'b0;
    check("held_accept_count", count, 4);
    exp_addr[0] = 32'h30; exp_data[0] = 32'h3;
    exp_addr[1] = 32'h40; exp_data[1] = 32'h4;
    exp_addr[2] = 32'h50; exp_data[2] = 32'h0000_AB05;
    exp_addr[3] = 32'h60; exp_data[3] = 32'h6;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_addr", i), bus.mem_addr, exp_addr[i]);
      check($sformatf("drain%0d_data", i), bus.mem_data, exp_data[i]);
      check($sformatf("drain%0d_be", i), bus.mem_byte_en, 4'hF);
      step();
    end
    check("drain_empty", empty, 1);
    step();
    check("empty_ready_count", count, 0);
    check("empty_ready_valid", bus.mem_valid, 0);
    bus.mem_ready = 1'b0;

    // COALESCE=0: same-word stores stay separate
    pulse_reset();
    enq_nc(32'h200, 32'h1111_1111, 4'hF);
    enq_nc(32'h200, 32'h0000_00AA, 4'h1);
    check("nc_count", count_nc, 2);
    bus_nc.lookup_addr = 32'h200;
    #1;
    check("nc_lk_data", bus_nc.lookup_data, 32'h1111_11AA);
    check("nc_lk_be", bus_nc.lookup_be, 4'hF);
    check("nc_d0_data", bus_nc.mem_data, 32'h1111_1111);
    check("nc_d0_be", bus_nc.mem_byte_en, 4'hF);
    bus_nc.mem_ready = 1'b1;
    step();
    check("nc_d1_addr", bus_nc.mem_addr, 32'h200);
    check("nc_d1_data", bus_nc.mem_data, 32'h0000_00AA);
    check("nc_d1_be", bus_nc.mem_byte_en, 4'h1);
    step();
    bus_nc.mem_ready = 1'b0;
    check("nc_empty", empty_nc, 1);

    // mem_ready toggling 1,0,1
    pulse_reset();
    enq(32'h300, 32'hA, 4'hF);
    enq(32'h304, 32'hB, 4'hF);
    enq(32'h308, 32'hC, 4'hF);
    bus.mem_ready = 1'b1;
    step();
    check("tog_pop1_count", count, 2);
    check("tog_pop1_addr", bus.mem_addr, 32'h304);
    bus.mem_ready = 1'b0;
    step();
    check("tog_stall_count", count, 2);
    check("tog_stall_addr", bus.mem_addr, 32'h304);
    check("tog_stall_data", bus.mem_data, 32'hB);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check("tog_pop2_count", count, 1);
    check("tog_pop2_addr", bus.mem_addr, 32'h308);

    // Asynchronous reset mid-drain
    pulse_reset();
    enq(32'h400, 32'h1, 4'hF);
    enq(32'h404, 32'h2, 4'hF);
    enq(32'h408, 32'h3, 4'hF);
    check("mid_count", count, 3);
    check("mid_valid", bus.mem_valid, 1);
    bus.mem_ready = 1'b1;
    bus.lookup_addr = 32'h400;
    #1;
    check("mid_lk_hit_pre", bus.lookup_hit, 1);
    reset = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_valid", bus.mem_valid, 0);
    check("async_empty", empty, 1);
    check("async_ready", bus.enq_ready, 1);
    check("async_lk_hit", bus.lookup_hit, 0);
    check("async_lk_data", bus.lookup_data, 0);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    bus.lookup_addr = 32'h404;
    #1;
    check("post_rst_lk_hit", bus.lookup_hit, 0);
    check("post_rst_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
